// File: rtl/nasti_pkg.sv
// Shared NASTI types: response codes, burst encodings, master FSM states and resp merging.
package nasti_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WRITE,
    ST_WRESP,
    ST_RSP
  } state_e;

  // Response codes are ordered by severity, so the worst is simply the larger.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nasti_if.sv
// NASTI channel bundle (AW, W, B, AR, R) with master and slave views.
interface nasti_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              aw_valid, aw_ready;
  logic [ID_W-1:0]   aw_id;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;

  logic                aw_unused_pad;
  logic                w_valid, w_ready, w_last;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;

  logic            b_valid, b_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0]      b_resp;

  logic              ar_valid, ar_ready;
  logic [ID_W-1:0]   ar_id;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;

  logic              r_valid, r_ready, r_last;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  assign aw_unused_pad = 1'b0;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output w_valid, w_data, w_strb, w_last,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp,
    input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp,
    output ar_ready, r_valid, r_id, r_data, r_resp, r_last
  );
endinterface

// File: rtl/nasti_master_port.sv
// Single-outstanding NASTI master: one core command -> AR/R or AW/W/B INCR burst -> one rsp (read len=0: rsp 3 cycles after cmd).
// cmd_ready only in IDLE; AR/AW/rsp are registered and held until ready; W and R pass straight through the wr/rd handshakes.
module nasti_master_port
  import nasti_pkg::*;
#(
  parameter int C_ID_WIDTH   = 4,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                      core_clk,
  input  logic                      core_arstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ID_WIDTH-1:0]     cmd_id,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [C_DATA_WIDTH-1:0]   wr_data,
  input  logic [C_DATA_WIDTH/8-1:0] wr_strb,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [C_DATA_WIDTH-1:0]   rd_data,
  output logic                      rd_last,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [C_ID_WIDTH-1:0]     rsp_id,
  output logic [1:0]                rsp_resp,
  nasti_if.master                   m_nasti
);

  state_e                    state;
  logic [C_ID_WIDTH-1:0]     id_q;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt;
  logic [2:0]                size_q;
  logic                      ar_valid_q, aw_valid_q, aw_done, w_done;
  logic                      rsp_valid_q, rsp_write_q, err_q;
  logic [1:0]                resp_q;

  logic       w_open, r_open, w_hs, r_hs, aw_hs, w_last_beat, r_err;
  logic [1:0] r_worst;

  assign cmd_ready   = (state == ST_IDLE);
  assign w_open      = (state == ST_WRITE) && !w_done;
  assign r_open      = (state == ST_RDATA);
  assign aw_hs       = aw_valid_q && m_nasti.aw_ready;
  assign w_hs        = w_open && wr_valid && m_nasti.w_ready;
  assign r_hs        = r_open && m_nasti.r_valid && rd_ready;
  assign w_last_beat = (beat_cnt == len_q);
  assign r_worst     = worst_resp(resp_q, m_nasti.r_resp);
  // Wrong ID, a beat past the requested length, or an early/late r_last all poison the burst.
  assign r_err = (m_nasti.r_id != id_q) || (beat_cnt > len_q) ||
                 (m_nasti.r_last && (beat_cnt != len_q));

  assign m_nasti.ar_valid = ar_valid_q;
  assign m_nasti.ar_id    = id_q;
  assign m_nasti.ar_addr  = addr_q;
  assign m_nasti.ar_len   = len_q;
  assign m_nasti.ar_size  = size_q;
  assign m_nasti.ar_burst = BURST_INCR;
  assign m_nasti.aw_valid = aw_valid_q;
  assign m_nasti.aw_id    = id_q;
  assign m_nasti.aw_addr  = addr_q;
  assign m_nasti.aw_len   = len_q;
  assign m_nasti.aw_size  = size_q;
  assign m_nasti.aw_burst = BURST_INCR;

  assign m_nasti.w_valid = w_open && wr_valid;
  assign m_nasti.w_data  = wr_data;
  assign m_nasti.w_strb  = wr_strb;
  assign m_nasti.w_last  = w_last_beat;
  assign wr_ready        = w_open && m_nasti.w_ready;

  assign m_nasti.r_ready = r_open && rd_ready;
  assign rd_valid        = r_open && m_nasti.r_valid;
  assign rd_data         = m_nasti.r_data;
  assign rd_last         = m_nasti.r_last;

  assign m_nasti.b_ready = (state == ST_WRESP);

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_id    = id_q;
  assign rsp_resp  = resp_q;

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state       <= ST_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      beat_cnt    <= '0;
      ar_valid_q  <= 1'b0;
      aw_valid_q  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      err_q       <= 1'b0;
      resp_q      <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          id_q        <= cmd_id;
          addr_q      <= cmd_addr;
          len_q       <= cmd_len;
          size_q      <= cmd_size;
          beat_cnt    <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          err_q       <= 1'b0;
          resp_q      <= RESP_OKAY;
          rsp_write_q <= cmd_write;
          if (cmd_write) begin
            aw_valid_q <= 1'b1;
            state      <= ST_WRITE;
          end else begin
            ar_valid_q <= 1'b1;
            state      <= ST_RADDR;
          end
        end
        ST_RADDR: if (m_nasti.ar_ready) begin
          ar_valid_q <= 1'b0;
          state      <= ST_RDATA;
        end
        ST_RDATA: if (r_hs) begin
          if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
          if (m_nasti.r_last) begin
            resp_q      <= (err_q || r_err) ? RESP_SLVERR : r_worst;
            rsp_valid_q <= 1'b1;
            state       <= ST_RSP;
          end else begin
            resp_q <= r_worst;
            err_q  <= err_q || r_err;
          end
        end
        ST_WRITE: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            if (w_last_beat) w_done <= 1'b1;
            else             beat_cnt <= beat_cnt + 8'd1;
          end
          // AW and the final W beat may land in either order or together.
          if ((aw_done || aw_hs) && (w_done || (w_hs && w_last_beat))) state <= ST_WRESP;
        end
        ST_WRESP: if (m_nasti.b_valid) begin
          resp_q      <= (m_nasti.b_id != id_q) ? RESP_SLVERR : m_nasti.b_resp;
          rsp_valid_q <= 1'b1;
          state       <= ST_RSP;
        end
        ST_RSP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nasti_master_port.sv
// Directed bench for nasti_master_port: the bench plays the NASTI slave and the core-side agent.
module tb_nasti_master_port;

  logic        core_clk = 1'b0;
  logic        core_arstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [3:0]  rsp_id;
  logic [1:0]  rsp_resp;

  int total = 0;
  int bad   = 0;

  nasti_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) nif ();

  nasti_master_port #(.C_ID_WIDTH(4), .C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) dut (
    .core_clk(core_clk), .core_arstn(core_arstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_id(rsp_id), .rsp_resp(rsp_resp),
    .m_nasti(nif)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge core_clk);
  endtask

  // Read of one beat with every ready high: cmd at N, AR at N+1, R at N+2, rsp at N+3.
  task automatic simple_read(input logic [3:0] id, input logic [31:0] addr, input logic [63:0] dat);
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = id; cmd_addr = addr; cmd_len = 8'd0; cmd_size = 3'd3;
    nif.ar_ready = 1'b1; rd_ready = 1'b1; rsp_ready = 1'b1;
    #1 chk("rd0_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0; cmd_id = ~id; cmd_addr = 32'hDEAD_BEEF;
    #1;
    chk("rd0_ar_valid", nif.ar_valid, 1);
    chk("rd0_ar_id", nif.ar_id, id);
    chk("rd0_ar_addr", nif.ar_addr, addr);
    chk("rd0_ar_len", nif.ar_len, 0);
    chk("rd0_ar_burst", nif.ar_burst, 1);
    chk("rd0_cmd_busy", cmd_ready, 0);
    tick;
    nif.r_valid = 1'b1; nif.r_id = id; nif.r_data = dat; nif.r_resp = 2'd0; nif.r_last = 1'b1;
    #1;
    chk("rd0_ar_drop", nif.ar_valid, 0);
    chk("rd0_rd_valid", rd_valid, 1);
    chk("rd0_rd_data", rd_data, dat);
    chk("rd0_rd_last", rd_last, 1);
    chk("rd0_r_ready", nif.r_ready, 1);
    tick;
    nif.r_valid = 1'b0; nif.r_last = 1'b0;
    #1;
    chk("rd0_rsp_valid", rsp_valid, 1);
    chk("rd0_rsp_id", rsp_id, id);
    chk("rd0_rsp_resp", rsp_resp, 0);
    chk("rd0_rsp_write", rsp_write, 0);
    tick;
    #1;
    chk("rd0_rsp_clear", rsp_valid, 0);
    chk("rd0_idle_again", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nbeats;
    int nlast;
    int last_idx;
    logic got;

    core_arstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0; rsp_ready = 1'b0;
    nif.ar_ready = 1'b0; nif.aw_ready = 1'b0; nif.w_ready = 1'b0;
    nif.b_valid = 1'b0; nif.b_id = '0; nif.b_resp = '0;
    nif.r_valid = 1'b0; nif.r_id = '0; nif.r_data = '0; nif.r_resp = '0; nif.r_last = 1'b0;

    // Reset state
    tick; tick;
    #1;
    chk("rst_ar_valid", nif.ar_valid, 0);
    chk("rst_aw_valid", nif.aw_valid, 0);
    chk("rst_w_valid", nif.w_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_r_ready", nif.r_ready, 0);
    chk("rst_b_ready", nif.b_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    tick;
    core_arstn = 1'b1;
    #1 chk("rel_cmd_ready", cmd_ready, 1);

    // Single-beat read, full latency check
    simple_read(4'd3, 32'h100, 64'h0123_4567_89AB_CDEF);

    // Write len=3; W runs two beats ahead of aw_ready
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd1; cmd_addr = 32'h200; cmd_len = 8'd3; cmd_size = 3'd3;
    nif.aw_ready = 1'b0; nif.w_ready = 1'b1; rsp_ready = 1'b0;
    #1 chk("wr_cmd_ready", cmd_ready, 1);
    tick;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'hD0; wr_strb = 8'hFF;
    #1;
    chk("wr_aw_valid", nif.aw_valid, 1);
    chk("wr_w_valid_b0", nif.w_valid, 1);
    chk("wr_w_last_b0", nif.w_last, 0);
    chk("wr_w_data_b0", nif.w_data, 64'hD0);
    chk("wr_wr_ready_b0", wr_ready, 1);
    tick;
    wr_data = 64'hD1;
    #1;
    chk("wr_w_last_b1", nif.w_last, 0);
    chk("wr_aw_hold", nif.aw_valid, 1);
    tick;
    nif.aw_ready = 1'b1; wr_data = 64'hD2; wr_strb = 8'h0F;
    #1;
    chk("wr_w_last_b2", nif.w_last, 0);
    chk("wr_w_strb_b2", nif.w_strb, 8'h0F);
    chk("wr_aw_addr", nif.aw_addr, 32'h200);
    chk("wr_aw_len", nif.aw_len, 3);
    chk("wr_aw_size", nif.aw_size, 3);
    chk("wr_aw_burst", nif.aw_burst, 1);
    tick;
    nif.aw_ready = 1'b0; wr_data = 64'hD3; wr_strb = 8'hFF;
    #1;
    chk("wr_aw_drop", nif.aw_valid, 0);
    chk("wr_w_last_b3", nif.w_last, 1);
    chk("wr_w_data_b3", nif.w_data, 64'hD3);
    tick;
    nif.b_valid = 1'b1; nif.b_id = 4'd1; nif.b_resp = 2'd0;
    #1;
    chk("wr_closed_wr_ready", wr_ready, 0);
    chk("wr_closed_w_valid", nif.w_valid, 0);
    chk("wr_b_ready", nif.b_ready, 1);
    tick;
    nif.b_valid = 1'b0; wr_valid = 1'b0;
    #1;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_write", rsp_write, 1);
    chk("wr_rsp_resp", rsp_resp, 0);
    chk("wr_rsp_id", rsp_id, 1);
    tick;
    #1 chk("wr_rsp_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick;
    #1 chk("wr_rsp_clear", rsp_valid, 0);

    // Read len=3 with one SLVERR beat
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd7; cmd_addr = 32'h300; cmd_len = 8'd3;
    nif.ar_ready = 1'b1; rd_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    #1 chk("rd3_ar_len", nif.ar_len, 3);
    for (int b = 0; b < 4; b++) begin
      tick;
      nif.r_valid = 1'b1; nif.r_id = 4'd7; nif.r_data = 64'hA0 + 64'(b);
      nif.r_resp = (b == 2) ? 2'd2 : 2'd0; nif.r_last = (b == 3);
      #1;
      chk("rd3_rd_valid", rd_valid, 1);
      chk("rd3_rd_data", rd_data, 64'hA0 + 64'(b));
      chk("rd3_rd_last", rd_last, (b == 3));
    end
    tick;
    nif.r_valid = 1'b0; nif.r_last = 1'b0;
    #1;
    chk("rd3_rsp_valid", rsp_valid, 1);
    chk("rd3_rsp_resp", rsp_resp, 2);
    chk("rd3_rsp_id", rsp_id, 7);

    // Read len=3 but slave ends after two beats
    tick;
    cmd_valid = 1'b1; cmd_id = 4'd8; cmd_addr = 32'h340; cmd_len = 8'd3;
    tick;
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      tick;
      nif.r_valid = 1'b1; nif.r_id = 4'd8; nif.r_data = 64'hC0 + 64'(b);
      nif.r_resp = 2'd0; nif.r_last = (b == 1);
      #1 chk("short_rd_valid", rd_valid, 1);
    end
    tick;
    nif.r_valid = 1'b0; nif.r_last = 1'b0;
    #1;
    chk("short_rsp_valid", rsp_valid, 1);
    chk("short_rsp_resp", rsp_resp, 2);

    // Read len=7 with random rd_ready / rsp_ready backpressure
    tick;
    cmd_valid = 1'b1; cmd_id = 4'hA; cmd_addr = 32'h500; cmd_len = 8'd7;
    tick;
    cmd_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      tick;
      nif.r_valid = 1'b1; nif.r_id = 4'hA; nif.r_data = 64'hB000 + 64'(k);
      nif.r_resp = 2'd0; nif.r_last = (k == 7);
      rd_ready = 1'($urandom_range(0, 1));
      #1;
      if (rd_ready) begin
        chk("bp_rd_valid", rd_valid, 1);
        chk("bp_rd_data", rd_data, 64'hB000 + 64'(k));
        k++;
      end
    end
    chk("bp_beats", k, 8);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick;
      nif.r_valid = 1'b0; nif.r_last = 1'b0;
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_rsp_held", rsp_valid, 1);
      chk("bp_rsp_resp", rsp_resp, 0);
      if (rsp_ready) got = 1'b1;
    end
    chk("bp_rsp_taken", got, 1);
    tick;
    rsp_ready = 1'b1; rd_ready = 1'b1;
    #1 chk("bp_rsp_clear", rsp_valid, 0);

    // Write len=0, W before AW, mismatching b_id
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd4; cmd_addr = 32'h400; cmd_len = 8'd0;
    nif.aw_ready = 1'b0; nif.w_ready = 1'b1;
    tick;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'hE0;
    #1;
    chk("bid_w_last", nif.w_last, 1);
    chk("bid_wr_ready", wr_ready, 1);
    tick;
    nif.aw_ready = 1'b1;
    #1;
    chk("bid_w_done", nif.w_valid, 0);
    chk("bid_aw_valid", nif.aw_valid, 1);
    chk("bid_no_b_ready", nif.b_ready, 0);
    tick;
    nif.aw_ready = 1'b0; wr_valid = 1'b0;
    nif.b_valid = 1'b1; nif.b_id = 4'd5; nif.b_resp = 2'd0;
    #1 chk("bid_b_ready", nif.b_ready, 1);
    tick;
    nif.b_valid = 1'b0;
    #1;
    chk("bid_rsp_valid", rsp_valid, 1);
    chk("bid_rsp_resp", rsp_resp, 2);
    chk("bid_rsp_id", rsp_id, 4);
    tick;
    #1 chk("bid_idle", cmd_ready, 1);

    // Reset asserted during the second W beat
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd2; cmd_addr = 32'h700; cmd_len = 8'd3;
    nif.aw_ready = 1'b0; nif.w_ready = 1'b1;
    tick;
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'hF0;
    tick;
    wr_data = 64'hF1;
    #1 chk("arst_w_valid_before", nif.w_valid, 1);
    core_arstn = 1'b0;
    #1;
    chk("arst_aw_valid", nif.aw_valid, 0);
    chk("arst_w_valid", nif.w_valid, 0);
    chk("arst_wr_ready", wr_ready, 0);
    chk("arst_b_ready", nif.b_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    tick;
    core_arstn = 1'b1; wr_valid = 1'b0;
    #1 chk("arst_cmd_ready", cmd_ready, 1);
    simple_read(4'd6, 32'h600, 64'h5555_AAAA_5555_AAAA);

    // Write len=255: 256 beats, w_last only on the final one
    tick;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd9; cmd_addr = 32'h1000; cmd_len = 8'd255;
    nif.aw_ready = 1'b1; nif.w_ready = 1'b1;
    nbeats = 0; nlast = 0; last_idx = -1; got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick;
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 64'(c);
      #1;
      if (nif.b_ready) begin
        got = 1'b1;
      end else if (nif.w_valid && nif.w_ready) begin
        if (nif.w_last) begin
          nlast++;
          last_idx = nbeats;
        end
        nbeats++;
      end
    end
    chk("long_reached_wresp", got, 1);
    chk("long_beats", nbeats, 256);
    chk("long_last_count", nlast, 1);
    chk("long_last_index", last_idx, 255);
    chk("long_wr_ready_closed", wr_ready, 0);
    nif.b_valid = 1'b1; nif.b_id = 4'd9; nif.b_resp = 2'd0;
    tick;
    nif.b_valid = 1'b0; wr_valid = 1'b0;
    #1;
    chk("long_rsp_valid", rsp_valid, 1);
    chk("long_rsp_resp", rsp_resp, 0);
    chk("long_rsp_write", rsp_write, 1);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
